// File: rtl/rf_write_arbiter_if.sv
// Writeback request bundle for the register-file write arbiter.
// Two independent valid/ready request channels (req0 = execute, req1 = load).
// The master modport is the writeback sources' view; the slave modport is the
// arbiter's view.
interface rf_write_arbiter_if #(
  parameter int RF_ADDR_LEN = 5,
  parameter int RF_DATA_LEN = 32
);

  logic                   req0_valid;
  logic [RF_ADDR_LEN-1:0] req0_addr;
  logic [RF_DATA_LEN-1:0] req0_data;
  logic                   req0_ready;

  logic                   req1_valid;
  logic [RF_ADDR_LEN-1:0] req1_addr;
  logic [RF_DATA_LEN-1:0] req1_data;
  logic                   req1_ready;

  // Writeback sources drive requests and observe the grant.
  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready
  );

  // The arbiter observes requests and returns the grant.
  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready
  );

endinterface

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter.
// Two writeback sources share one register-file write port. A round-robin
// pointer picks the winner when both are valid; the winning write is captured
// in a single-entry output stage that drives the register file directly.
// Writes to x0 complete the handshake but never raise the write enable.
// The output stage is also exposed to decode as a forwarding source, and a
// saturating counter records how many cycles both sources collided.
module rf_write_arbiter #(
  parameter int RF_ADDR_LEN = 5,
  parameter int RF_DATA_LEN = 32,
  parameter int CNT_LEN     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,

  rf_write_arbiter_if.slave      req,

  output logic                   w_en,
  output logic [RF_ADDR_LEN-1:0] rd_addr,
  output logic [RF_DATA_LEN-1:0] rd_write_data,

  input  logic [RF_ADDR_LEN-1:0] rs1_addr,
  input  logic [RF_ADDR_LEN-1:0] rs2_addr,
  output logic                   fwd1_hit,
  output logic                   fwd2_hit,
  output logic [RF_DATA_LEN-1:0] fwd1_data,
  output logic [RF_DATA_LEN-1:0] fwd2_data,

  output logic [CNT_LEN-1:0]     contention_cnt
);

  localparam logic [CNT_LEN-1:0]     CNT_MAX   = '1;
  localparam logic [RF_ADDR_LEN-1:0] ADDR_ZERO = '0;

  // Round-robin pointer: 0 favours req0, 1 favours req1 on contention.
  logic                   prio_q, prio_d;

  // Output stage feeding the register-file write port.
  logic                   w_en_q, w_en_d;
  logic [RF_ADDR_LEN-1:0] rd_addr_q, rd_addr_d;
  logic [RF_DATA_LEN-1:0] rd_data_q, rd_data_d;

  logic [CNT_LEN-1:0]     cnt_q, cnt_d;

  logic                   both_valid;
  logic                   grant0;
  logic                   grant1;
  logic                   xfer0;
  logic                   xfer1;
  logic                   xfer;
  logic [RF_ADDR_LEN-1:0] win_addr;
  logic [RF_DATA_LEN-1:0] win_data;

  assign both_valid = req.req0_valid & req.req1_valid;

  // Grant: a lone requester always wins; on a tie the pointer decides.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (both_valid) begin
      grant0 = ~prio_q;
      grant1 =  prio_q;
    end else if (req.req0_valid) begin
      grant0 = 1'b1;
    end else if (req.req1_valid) begin
      grant1 = 1'b1;
    end
  end

  // Ready is purely combinational and only ever asserted for a valid request,
  // so a ready is a completed transfer at the next edge.
  assign xfer0 = req.req0_valid & grant0;
  assign xfer1 = req.req1_valid & grant1;
  assign xfer  = xfer0 | xfer1;

  assign req.req0_ready = xfer0;
  assign req.req1_ready = xfer1;

  // Mux the winning request's payload.
  always_comb begin
    win_addr = req.req0_addr;
    win_data = req.req0_data;
    if (xfer1) begin
      win_addr = req.req1_addr;
      win_data = req.req1_data;
    end
  end

  // Next-state: pointer hands priority to the other source after a transfer;
  // the output stage pulses w_en for one cycle per non-x0 write and otherwise
  // holds address/data so the forwarding compare stays stable.
  always_comb begin
    prio_d    = prio_q;
    w_en_d    = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    cnt_d     = cnt_q;

    if (xfer0) begin
      prio_d = 1'b1;
    end else if (xfer1) begin
      prio_d = 1'b0;
    end

    if (xfer && (win_addr != ADDR_ZERO)) begin
      w_en_d    = 1'b1;
      rd_addr_d = win_addr;
      rd_data_d = win_data;
    end

    if (both_valid && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers; async reset discards any in-flight write immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q    <= 1'b0;
      w_en_q    <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      cnt_q     <= '0;
    end else begin
      prio_q    <= prio_d;
      w_en_q    <= w_en_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      cnt_q     <= cnt_d;
    end
  end

  assign w_en           = w_en_q;
  assign rd_addr        = rd_addr_q;
  assign rd_write_data  = rd_data_q;
  assign contention_cnt = cnt_q;

  // Forwarding: only the write sitting in the output stage is visible here;
  // once committed, decode reads it from the register file. x0 never hits.
  always_comb begin
    fwd1_hit  = w_en_q && (rd_addr_q == rs1_addr) && (rs1_addr != ADDR_ZERO);
    fwd2_hit  = w_en_q && (rd_addr_q == rs2_addr) && (rs2_addr != ADDR_ZERO);
    fwd1_data = fwd1_hit ? rd_data_q : '0;
    fwd2_data = fwd2_hit ? rd_data_q : '0;
  end

endmodule
